// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: EX/MEM -> MEM/WB pipeline stage with a req/gnt/rvalid data-memory port
// Ports:
//   MEM_CLOCK, MEM_RESET        rising-edge clock, asynchronous active-low reset
//   in_*  / in_ready            EX-side valid/ready handshake and instruction operands
//   flush                       kills the instruction currently owned by this stage
//   dmem_*                      registered request (req/we/addr/wdata/be), gnt, rvalid/rdata
//   out_* / out_ready           MEM/WB register with valid/ready handshake
//   misalign                    one-cycle pulse on a trapped misaligned access
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of issuing
//   them with a truncated, lane-shifted strobe.
module mem_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int BE_W  = XLEN / 8,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic            MEM_CLOCK,
    input  logic            MEM_RESET,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc_4,
    input  logic [XLEN-1:0] in_alu_out,
    input  logic [XLEN-1:0] in_rs2,
    input  logic            in_mem_we,
    input  logic            in_mem_rd,
    input  logic [1:0]      in_rf_wr_sel,
    input  logic            in_reg_write,
    input  logic            flush,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [BE_W-1:0] dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc_4,
    output logic [XLEN-1:0] out_alu_result,
    output logic [XLEN-1:0] out_load_data,
    output logic [31:0]     out_ir,
    output logic [1:0]      out_rf_wr_sel,
    output logic            out_reg_write,
    output logic            misalign
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] RSP   = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;
    localparam logic [XLEN-1:0] ONES = '1;
    localparam logic [XLEN-1:0] M8   = ~(ONES << 8);
    localparam logic [XLEN-1:0] M16  = ~(ONES << 16);
    localparam logic [XLEN-1:0] M32  = ~(ONES << 32);
    logic [2:0]      state;
    logic [31:0]     q_ir;
    logic [XLEN-1:0] q_pc_4, q_alu, q_rs2, hold_data, sh, ld, cap_data;
    logic [1:0]      q_sel;
    logic            q_we, q_reg_write, out_rw;
    logic            out_free, accept, mem_op, mis, cap, idle;
    logic [OFF_W-1:0] lane;
    logic [2:0]      f3;
    logic [7:0]      size_mask;
    assign idle     = state == IDLE;
    assign out_free = !out_valid || out_ready;
    assign in_ready = idle && out_free;
    assign accept   = in_ready && in_valid && !flush;
    assign mem_op   = in_mem_rd || in_mem_we;
    // Memory-side signals all derive from the latched operands, so they hold still while waiting for gnt.
    assign lane       = q_alu[OFF_W-1:0];
    assign f3         = q_ir[14:12];
    assign size_mask  = f3[1:0] == 2'd0 ? 8'h01 : f3[1:0] == 2'd1 ? 8'h03 : f3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
    assign dmem_addr  = {q_alu[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign dmem_wdata = q_rs2 << {lane, 3'b000};
    // Strobes past the top lane fall off the cast, dropping bytes beyond the word boundary.
    assign dmem_be    = dmem_req ? BE_W'({8'h00, size_mask} << lane) : '0;
    assign dmem_we    = dmem_req && q_we;
    assign sh = dmem_rdata >> {lane, 3'b000};
    assign ld = f3 == 3'b000 ? (sh & M8)  | (~M8  & {XLEN{sh[7]}})
              : f3 == 3'b100 ? sh & M8
              : f3 == 3'b001 ? (sh & M16) | (~M16 & {XLEN{sh[15]}})
              : f3 == 3'b101 ? sh & M16
              : f3 == 3'b010 ? (sh & M32) | (~M32 & {XLEN{sh[31]}})
              : (f3 == 3'b110 && XLEN == 64) ? sh & M32
              : (f3 == 3'b011 && XLEN == 64) ? sh
              : '0;
`ifdef MEM_MISALIGN_TRAP_EN
    logic [2:0] in_size_m1;
    assign in_size_m1 = in_ir[13:12] == 2'd0 ? 3'd0 : in_ir[13:12] == 2'd1 ? 3'd1 : in_ir[13:12] == 2'd2 ? 3'd3 : 3'd7;
    assign mis = mem_op && |(3'(in_alu_out[OFF_W-1:0]) & in_size_m1);
    always_ff @(posedge MEM_CLOCK or negedge MEM_RESET)
        if (!MEM_RESET) misalign <= 1'b0;
        else            misalign <= accept && mis;
`else
    assign mis      = 1'b0;
    assign misalign = 1'b0;
`endif
    // A trapped misaligned access retires like an ALU op, straight from the inputs, with no write-back.
    assign cap = (accept && (!mem_op || mis))
              || (state == REQ  && dmem_gnt && q_we && out_free)
              || (state == RSP  && dmem_rvalid && !flush && out_free)
              || (state == HOLD && out_free && !flush);
    assign cap_data      = state == RSP ? ld : state == HOLD ? hold_data : '0;
    assign out_reg_write = out_valid && out_rw;
    always_ff @(posedge MEM_CLOCK or negedge MEM_RESET) begin
        if (!MEM_RESET) begin
            state          <= IDLE;
            dmem_req       <= 1'b0;
            q_ir           <= '0;
            q_pc_4         <= '0;
            q_alu          <= '0;
            q_rs2          <= '0;
            q_sel          <= '0;
            q_we           <= 1'b0;
            q_reg_write    <= 1'b0;
            hold_data      <= '0;
            out_valid      <= 1'b0;
            out_ir         <= '0;
            out_pc_4       <= '0;
            out_alu_result <= '0;
            out_load_data  <= '0;
            out_rf_wr_sel  <= '0;
            out_rw         <= 1'b0;
        end else begin
            if (cap) begin
                out_valid      <= 1'b1;
                out_ir         <= idle ? in_ir : q_ir;
                out_pc_4       <= idle ? in_pc_4 : q_pc_4;
                out_alu_result <= idle ? in_alu_out : q_alu;
                out_rf_wr_sel  <= idle ? in_rf_wr_sel : q_sel;
                out_rw         <= idle ? in_reg_write && !mis : q_reg_write;
                out_load_data  <= cap_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: if (accept && mem_op && !mis) begin
                    q_ir        <= in_ir;
                    q_pc_4      <= in_pc_4;
                    q_alu       <= in_alu_out;
                    q_rs2       <= in_rs2;
                    q_sel       <= in_rf_wr_sel;
                    q_we        <= in_mem_we;
                    q_reg_write <= in_reg_write;
                    hold_data   <= '0;
                    dmem_req    <= 1'b1;
                    state       <= REQ;
                end
                // A grant in the same cycle as flush commits the access; the load's data is drained later.
                REQ: if (dmem_gnt) begin
                    dmem_req <= 1'b0;
                    state    <= q_we ? (out_free ? IDLE : HOLD) : (flush ? DRAIN : RSP);
                end else if (flush) begin
                    dmem_req <= 1'b0;
                    state    <= IDLE;
                end
                // Data arriving together with flush is already the response, so discard it here instead of draining.
                RSP: if (dmem_rvalid) begin
                    hold_data <= ld;
                    state     <= (flush || out_free) ? IDLE : HOLD;
                end else if (flush) begin
                    state <= DRAIN;
                end
                HOLD:  if (flush || out_free) state <= IDLE;
                DRAIN: if (dmem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
